regfile_sb: RTL and testbench

Parametrised integer register file with a per-register busy scoreboard and a post-reset clearing sweep, for the decode/writeback stages of the pipelined RV32I core. Supports two combinational read ports with write-through bypass, one write port, and an issue port that marks a destination register pending until its writeback lands. Hazard logic uses the busy outputs to stall. It replaces the negedge-written register file with a single-edge design.

---
 rtl/regfile_sb_if.sv | 40 ++++
 rtl/regfile_sb.sv | 142 ++++++++++++++
 tb/tb_regfile_sb.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Bus bundle for regfile_sb: two read ports with busy flags,
//               one writeback port, one issue port and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   read_addr1;
    logic [AW-1:0]   read_addr2;
    logic [XLEN-1:0] read_data1;
    logic [XLEN-1:0] read_data2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wr_en;
    logic [AW-1:0]   write_addr;
    logic [XLEN-1:0] w_data;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            ready;
    logic [AW:0]     pend_cnt;

    // Pipeline side: drives addresses, writeback and issue.
    modport master (
        output read_addr1, read_addr2, wr_en, write_addr, w_data, iss_en, iss_addr,
        input  read_data1, read_data2, rs1_busy, rs2_busy, ready, pend_cnt
    );

    // Register-file side.
    modport slave (
        input  read_addr1, read_addr2, wr_en, write_addr, w_data, iss_en, iss_addr,
        output read_data1, read_data2, rs1_busy, rs2_busy, ready, pend_cnt
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Integer register file with write-through read bypass, a
//               per-register pending scoreboard and a post-reset sweep that
//               zeroes every register before traffic is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] c_last = AW'(NREGS - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_cnt;
    logic [XLEN-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [AW:0]     r_pend_cnt;

    logic            w_ready;
    logic            w_wr_act;
    logic            w_iss_act;
    logic            w_inc;
    logic            w_dec;
    logic            w_same;

    assign w_ready   = (r_state == ST_RUN);
    assign w_wr_act  = w_ready & bus.wr_en  & (bus.write_addr != '0);
    assign w_iss_act = w_ready & bus.iss_en & (bus.iss_addr   != '0);
    assign w_same    = (bus.iss_addr == bus.write_addr);

    // A count step follows each pending bit that actually flips; an issue
    // landing on the register being written keeps that bit set.
    assign w_inc = w_iss_act & ~r_pend[bus.iss_addr];
    assign w_dec = w_wr_act & r_pend[bus.write_addr] & ~(w_iss_act & w_same);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave INIT on the edge that clears the last register.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: if (r_cnt == c_last) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    // Sweep counter walks every register index while in INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + AW'(1);
        end
    end

    // Storage: zeroed by the sweep, otherwise written by writeback.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_regs[r_cnt] <= '0;
        end else if (w_wr_act && !rst) begin
            r_regs[bus.write_addr] <= bus.w_data;
        end
    end

    // Pending bits: writeback clears, issue sets; the later assignment lets a
    // same-edge issue (newer producer) win over the writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            if (w_wr_act)  r_pend[bus.write_addr] <= 1'b0;
            if (w_iss_act) r_pend[bus.iss_addr]   <= 1'b1;
        end
    end

    // Running count of set pending bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_cnt <= '0;
        end else if (w_inc && !w_dec) begin
            r_pend_cnt <= r_pend_cnt + (AW+1)'(1);
        end else if (w_dec && !w_inc) begin
            r_pend_cnt <= r_pend_cnt - (AW+1)'(1);
        end
    end

    // Read port 1: x0 reads zero, in-flight writeback is bypassed.
    always_comb begin
        bus.read_data1 = '0;
        if (w_ready && bus.read_addr1 != '0) begin
            if (bus.wr_en && bus.write_addr == bus.read_addr1) begin
                bus.read_data1 = bus.w_data;
            end else begin
                bus.read_data1 = r_regs[bus.read_addr1];
            end
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        bus.read_data2 = '0;
        if (w_ready && bus.read_addr2 != '0) begin
            if (bus.wr_en && bus.write_addr == bus.read_addr2) begin
                bus.read_data2 = bus.w_data;
            end else begin
                bus.read_data2 = r_regs[bus.read_addr2];
            end
        end
    end

    // A writeback landing this cycle releases the reader immediately.
    assign bus.rs1_busy = w_ready & r_pend[bus.read_addr1]
                        & ~(bus.wr_en & (bus.write_addr == bus.read_addr1) & (bus.read_addr1 != '0));
    assign bus.rs2_busy = w_ready & r_pend[bus.read_addr2]
                        & ~(bus.wr_en & (bus.write_addr == bus.read_addr2) & (bus.read_addr2 != '0));

    assign bus.ready    = w_ready;
    assign bus.pend_cnt = r_pend_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb: directed scenarios with
//               literal expectations plus randomized traffic compared every
//               cycle against a behavioural register/scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Behavioural model: architectural contents, pending set, ready flag.
    logic [XLEN-1:0] mreg [NREGS];
    bit              mpend [NREGS];
    bit              mready = 1'b0;
    int              msweep = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(mpend[i]);
        return c;
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (!mready || a == 0) return '0;
        if (bus.wr_en && bus.write_addr == a) return bus.w_data;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!mready || a == 0) return 1'b0;
        if (bus.wr_en && bus.write_addr == a) return 1'b0;
        return mpend[a];
    endfunction

    // Model advances on every rising edge from the inputs held across it.
    always @(posedge clk) begin
        if (rst) begin
            mready = 1'b0;
            msweep = 0;
            for (int i = 0; i < NREGS; i++) mpend[i] = 1'b0;
        end else if (!mready) begin
            msweep++;
            if (msweep == NREGS) begin
                mready = 1'b1;
                for (int i = 0; i < NREGS; i++) mreg[i] = '0;
            end
        end else begin
            if (bus.wr_en && bus.write_addr != 0) begin
                mreg[bus.write_addr]  = bus.w_data;
                mpend[bus.write_addr] = 1'b0;
            end
            if (bus.iss_en && bus.iss_addr != 0) mpend[bus.iss_addr] = 1'b1;
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ready", 64'(bus.ready), 64'(mready));
            check("m_pend_cnt", 64'(bus.pend_cnt), 64'(mcount()));
            check("m_rd1", 64'(bus.read_data1), 64'(exp_rd(bus.read_addr1)));
            check("m_rd2", 64'(bus.read_data2), 64'(exp_rd(bus.read_addr2)));
            check("m_busy1", 64'(bus.rs1_busy), 64'(exp_busy(bus.read_addr1)));
            check("m_busy2", 64'(bus.rs2_busy), 64'(exp_busy(bus.read_addr2)));
        end
    end

    task automatic idle();
        bus.read_addr1 = '0; bus.read_addr2 = '0;
        bus.wr_en = 1'b0; bus.write_addr = '0; bus.w_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        bus.read_addr1 = 5'd5;
        #1;
        check("reset_ready", 64'(bus.ready), 64'd0);
        check("reset_pend", 64'(bus.pend_cnt), 64'd0);
        check("reset_rd1", 64'(bus.read_data1), 64'd0);

        // Sweep: issue presented at edge 10 must be ignored.
        rst = 1'b0;
        for (int i = 1; i <= NREGS; i++) begin
            idle();
            if (i == 10) begin bus.iss_en = 1'b1; bus.iss_addr = 5'd4; end
            cyc();
            check("sweep_ready", 64'(bus.ready), (i == NREGS) ? 64'd1 : 64'd0);
        end
        idle(); bus.read_addr1 = 5'd4; bus.read_addr2 = 5'd17;
        #1;
        check("sweep_iss_busy", 64'(bus.rs1_busy), 64'd0);
        check("sweep_iss_pend", 64'(bus.pend_cnt), 64'd0);
        check("sweep_rd2_zero", 64'(bus.read_data2), 64'd0);

        // Write with same-cycle bypass, then from storage.
        bus.wr_en = 1'b1; bus.write_addr = 5'd5; bus.w_data = 32'hDEADBEEF; bus.read_addr1 = 5'd5;
        #1 check("bypass_rd1", 64'(bus.read_data1), 64'hDEADBEEF);
        cyc(); idle(); bus.read_addr1 = 5'd5;
        #1 check("stored_rd1", 64'(bus.read_data1), 64'hDEADBEEF);

        // Write to x0 has no effect.
        bus.wr_en = 1'b1; bus.write_addr = 5'd0; bus.w_data = 32'h1234; bus.read_addr1 = 5'd0;
        #1 check("x0_bypass", 64'(bus.read_data1), 64'd0);
        cyc(); idle();
        #1 check("x0_stored", 64'(bus.read_data1), 64'd0);

        // Scoreboard issue then writeback.
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        cyc(); idle(); bus.read_addr1 = 5'd7;
        #1;
        check("iss7_busy", 64'(bus.rs1_busy), 64'd1);
        check("iss7_pend", 64'(bus.pend_cnt), 64'd1);
        bus.wr_en = 1'b1; bus.write_addr = 5'd7; bus.w_data = 32'h55;
        #1;
        check("wb7_busy", 64'(bus.rs1_busy), 64'd0);
        check("wb7_rd1", 64'(bus.read_data1), 64'h55);
        cyc(); idle(); bus.read_addr1 = 5'd7;
        #1;
        check("wb7_pend", 64'(bus.pend_cnt), 64'd0);
        check("wb7_stored", 64'(bus.read_data1), 64'h55);

        // x9 pending, then same-edge issue+write keeps it pending.
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        cyc(); idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        bus.wr_en = 1'b1; bus.write_addr = 5'd9; bus.w_data = 32'h99;
        cyc(); idle(); bus.read_addr1 = 5'd9;
        #1;
        check("x9_data", 64'(bus.read_data1), 64'h99);
        check("x9_busy", 64'(bus.rs1_busy), 64'd1);
        check("x9_pend", 64'(bus.pend_cnt), 64'd1);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        cyc(); idle();
        #1 check("x9_reissue_pend", 64'(bus.pend_cnt), 64'd1);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        cyc(); idle(); bus.read_addr1 = 5'd0;
        #1;
        check("x0_iss_pend", 64'(bus.pend_cnt), 64'd1);
        check("x0_iss_busy", 64'(bus.rs1_busy), 64'd0);

        // Randomized traffic with occasional reset; the model checks each cycle.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.read_addr1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            bus.read_addr2 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            bus.wr_en      = ($urandom_range(0, 9) < 4);
            bus.write_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            bus.w_data     = $urandom;
            bus.iss_en     = ($urandom_range(0, 9) < 4);
            bus.iss_addr   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            cyc();
        end

        // Clean restart, then reset in the middle of RUN.
        idle(); rst = 1'b1;
        cyc(); rst = 1'b0;
        repeat (NREGS) cyc();
        #1 check("restart_ready", 64'(bus.ready), 64'd1);
        bus.wr_en = 1'b1; bus.write_addr = 5'd3; bus.w_data = 32'hA5;
        cyc();
        for (int r = 10; r < 14; r++) begin
            idle(); bus.iss_en = 1'b1; bus.iss_addr = AW'(r);
            cyc();
        end
        idle(); bus.read_addr1 = 5'd3;
        #1;
        check("mid_x3", 64'(bus.read_data1), 64'hA5);
        check("mid_pend4", 64'(bus.pend_cnt), 64'd4);
        rst = 1'b1;
        cyc(); rst = 1'b0;
        #1;
        check("mid_rst_ready", 64'(bus.ready), 64'd0);
        check("mid_rst_pend", 64'(bus.pend_cnt), 64'd0);
        check("mid_rst_rd", 64'(bus.read_data1), 64'd0);
        repeat (NREGS - 1) cyc();
        #1 check("mid_sweep_not_ready", 64'(bus.ready), 64'd0);
        cyc();
        #1;
        check("mid_sweep_ready", 64'(bus.ready), 64'd1);
        check("mid_x3_cleared", 64'(bus.read_data1), 64'd0);
        check("mid_busy_clear", 64'(bus.rs1_busy), 64'd0);

        repeat (2) cyc();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
